// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM states and access-rule helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int TIMEOUT = 255;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;
  // unlisted funct3 encodings report as misaligned so they never reach memory
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3 == F3_B || f3 == F3_BU) ? 1'b0 :
           (f3 == F3_H || f3 == F3_HU) ? a[0] :
           (f3 == F3_W) ? |a : 1'b1;
  endfunction
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    return (f3 == F3_B || f3 == F3_BU) ? 4'b0001 << a :
           (f3 == F3_H || f3 == F3_HU) ? 4'b0011 << a : 4'b1111;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/ready/valid data-memory port with byte enables
interface load_store_unit_if #(parameter int ADDR_W = 32);
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic [3:0]        memBe;
  logic              memReady;
  logic              memRvalid;
  logic [31:0]       memRdata;
  modport master(output memReq, memWe, memAddr, memWdata, memBe, input memReady, memRvalid, memRdata);
  modport slave(input memReq, memWe, memAddr, memWdata, memBe, output memReady, memRvalid, memRdata);
endinterface

// File: rtl/load_aligner.sv
// load_aligner: selects the addressed byte/halfword lane and sign- or zero-extends it
module load_aligner
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  ea,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{ea, 3'b000} +: 8];
  assign h = rdata[{ea[1], 4'b0000} +: 16];
  assign value = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_BU ? {24'b0, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_HU ? {16'b0, h} : rdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access stage; LSU_TIMEOUT_EN adds an abort on a stalled memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               isStore,
  input  logic [2:0]         funct3,
  input  logic [31:0]        baseAddr,
  input  logic [31:0]        offset32,
  input  logic [31:0]        storeData,
  output logic               busy,
  output logic               done,
  output logic [31:0]        loadData,
  output logic               misaligned,
  output logic               timeout,
  load_store_unit_if.master  mem
);
  state_t            state, state_n;
  logic [31:0]       ea, ld_val, st_val, wdata;
  logic [ADDR_W-1:0] ea_q;
  logic [2:0]        f3_q;
  logic              store_q, mis_in, mis_q, tmo_fire, launch;
  logic [31:0]       wdata_q, load_q;
  logic [3:0]        be_q;
  assign ea     = baseAddr + offset32;
  assign mis_in = is_misaligned(funct3, ea[1:0]);
  assign launch = state == IDLE && start;
  load_aligner u_ld (.rdata(mem.memRdata), .ea(ea_q[1:0]), .funct3(f3_q), .value(ld_val));
  // forcing the unsigned variant at lane 0 yields the raw low byte/halfword to replicate
  load_aligner u_st (.rdata(storeData), .ea(2'b00), .funct3({1'b1, funct3[1:0]}), .value(st_val));
  assign wdata = funct3[1:0] == 2'b00 ? {4{st_val[7:0]}} :
                 funct3[1:0] == 2'b01 ? {2{st_val[15:0]}} : st_val;
`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) < 8 ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             tmo_q;
  assign tmo_fire = (state == REQ && !mem.memReady || state == WAIT_RD && !mem.memRvalid) &&
                    cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign timeout  = tmo_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt   <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt   <= (state != REQ && state_n == REQ) ? '0 : busy ? cnt + 1'b1 : cnt;
      tmo_q <= launch ? 1'b0 : tmo_fire ? 1'b1 : tmo_q;
    end
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? (mis_in ? DONE : REQ) : IDLE;
      REQ:     state_n = mem.memReady ? (store_q ? DONE : WAIT_RD) : tmo_fire ? DONE : REQ;
      WAIT_RD: state_n = (mem.memRvalid || tmo_fire) ? DONE : WAIT_RD;
      DONE:    state_n = IDLE;
    endcase
  end
  always_comb begin
    busy       = state == REQ || state == WAIT_RD;
    done       = state == DONE;
    mem.memReq = state == REQ;
    mem.memWe  = state == REQ && store_q;
  end
  assign mem.memAddr  = {ea_q[ADDR_W-1:2], 2'b00};
  assign mem.memWdata = wdata_q;
  assign mem.memBe    = be_q;
  assign loadData     = load_q;
  assign misaligned   = mis_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      ea_q    <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      mis_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      if (launch) begin
        ea_q    <= ea[ADDR_W-1:0];
        f3_q    <= funct3;
        store_q <= isStore;
        wdata_q <= wdata;
        be_q    <= isStore ? lane_be(funct3, ea[1:0]) : 4'b1111;
        mis_q   <= mis_in;
      end
      if (state == WAIT_RD && mem.memRvalid) load_q <= ld_val;
    end
endmodule
